// File: rtl/fetch_inst_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_inst_queue
//  Purpose  : In-order instruction queue between the AXI4 fetch unit and
//             decode. Holds {pc, instr, fault} entries, presents the oldest
//             entry through a valid/ready handshake, empties in one cycle on
//             a redirect, and drops stale AXI responses using an epoch bit.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_inst_queue #(
  parameter int DEPTH     = 8,
  parameter int AF_MARGIN = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       enq_valid_i,
  output logic                       enq_ready_o,
  input  logic [31:0]                enq_pc_i,
  input  logic [31:0]                enq_instr_i,
  input  logic                       enq_fault_i,
  input  logic                       enq_epoch_i,
  output logic                       epoch_o,
  output logic                       deq_valid_o,
  input  logic                       deq_ready_i,
  output logic [31:0]                deq_pc_o,
  output logic [31:0]                deq_instr_o,
  output logic                       deq_fault_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       almost_full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AF_THRESH = PW'(DEPTH - AF_MARGIN);

  // Storage is deliberately left without reset; only slots between the
  // pointers are ever observed on the outputs.
  logic [31:0] pc_mem_q    [DEPTH];
  logic [31:0] instr_mem_q [DEPTH];
  logic        fault_mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          epoch_q,  epoch_d;

  logic          w_empty;
  logic          w_full;
  logic          w_enq_fire;
  logic          w_deq_fire;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_rd_idx;
  logic [PW-1:0] w_count;

  assign w_wr_idx = wr_ptr_q[AW-1:0];
  assign w_rd_idx = rd_ptr_q[AW-1:0];

  // The extra pointer MSB separates the full case from the empty case.
  assign w_empty = (rd_ptr_q == wr_ptr_q);
  assign w_full  = (w_wr_idx == w_rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign w_count = wr_ptr_q - rd_ptr_q;

  // A response from an older epoch still completes its handshake (so the
  // AXI read channel drains) but never reaches storage.
  assign w_enq_fire = enq_valid_i && !w_full && !flush_i && (enq_epoch_i == epoch_q);
  assign w_deq_fire = !w_empty && deq_ready_i && !flush_i;

  assign enq_ready_o   = !w_full;
  assign deq_valid_o   = !w_empty;
  assign epoch_o       = epoch_q;
  assign count_o       = w_count;
  assign almost_full_o = (w_count >= AF_THRESH);

  // Head entry is forced to zero when empty so decode never sees X.
  assign deq_pc_o    = w_empty ? 32'h0 : pc_mem_q[w_rd_idx];
  assign deq_instr_o = w_empty ? 32'h0 : instr_mem_q[w_rd_idx];
  assign deq_fault_o = w_empty ? 1'b0  : fault_mem_q[w_rd_idx];

  // Next-state for pointers and epoch; a redirect overrides all traffic.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    epoch_d  = epoch_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      epoch_d  = ~epoch_q;
    end else begin
      if (w_enq_fire) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (w_deq_fire) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
    end
  end

  // Pointer and epoch registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      epoch_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      epoch_q  <= epoch_d;
    end
  end

  // Entry write at the tail slot on an accepted enqueue.
  always_ff @(posedge clk) begin
    if (w_enq_fire) begin
      pc_mem_q[w_wr_idx]    <= enq_pc_i;
      instr_mem_q[w_wr_idx] <= enq_instr_i;
      fault_mem_q[w_wr_idx] <= enq_fault_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_inst_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_inst_queue
//  Purpose  : Self-checking bench for fetch_inst_queue using a scoreboard
//             queue of expected entries plus a reference occupancy/epoch.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_inst_queue;

  localparam int DEPTH     = 8;
  localparam int AF_MARGIN = 2;
  localparam int CW        = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush_i;
  logic          enq_valid_i;
  logic          enq_ready_o;
  logic [31:0]   enq_pc_i;
  logic [31:0]   enq_instr_i;
  logic          enq_fault_i;
  logic          enq_epoch_i;
  logic          epoch_o;
  logic          deq_valid_o;
  logic          deq_ready_i;
  logic [31:0]   deq_pc_o;
  logic [31:0]   deq_instr_o;
  logic          deq_fault_o;
  logic [CW-1:0] count_o;
  logic          almost_full_o;

  int   n_cmp = 0;
  int   n_err = 0;
  ent_t sb[$];
  int   m_cnt = 0;
  logic m_epoch = 1'b0;

  fetch_inst_queue #(.DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush_i       (flush_i),
    .enq_valid_i   (enq_valid_i),
    .enq_ready_o   (enq_ready_o),
    .enq_pc_i      (enq_pc_i),
    .enq_instr_i   (enq_instr_i),
    .enq_fault_i   (enq_fault_i),
    .enq_epoch_i   (enq_epoch_i),
    .epoch_o       (epoch_o),
    .deq_valid_o   (deq_valid_o),
    .deq_ready_i   (deq_ready_i),
    .deq_pc_o      (deq_pc_o),
    .deq_instr_o   (deq_instr_o),
    .deq_fault_o   (deq_fault_o),
    .count_o       (count_o),
    .almost_full_o (almost_full_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output against the reference model state.
  task automatic check_outputs(input string tag);
    check({tag, " count"}, 64'(count_o), 64'(m_cnt));
    check({tag, " epoch"}, 64'(epoch_o), 64'(m_epoch));
    check({tag, " deq_valid"}, 64'(deq_valid_o), 64'(m_cnt != 0));
    check({tag, " enq_ready"}, 64'(enq_ready_o), 64'(m_cnt < DEPTH));
    check({tag, " almost_full"}, 64'(almost_full_o), 64'(m_cnt >= DEPTH - AF_MARGIN));
    if (m_cnt == 0) begin
      check({tag, " empty pc"}, 64'(deq_pc_o), 64'h0);
      check({tag, " empty instr"}, 64'(deq_instr_o), 64'h0);
      check({tag, " empty fault"}, 64'(deq_fault_o), 64'h0);
    end else begin
      check({tag, " head pc"}, 64'(deq_pc_o), 64'(sb[0].pc));
      check({tag, " head instr"}, 64'(deq_instr_o), 64'(sb[0].instr));
      check({tag, " head fault"}, 64'(deq_fault_o), 64'(sb[0].fault));
    end
  endtask

  // Drive one cycle of stimulus (called at a falling edge), advance the
  // model at the rising edge, then check outputs at the next falling edge.
  task automatic cycle(input bit ev, input logic [31:0] pc, input bit flt,
                       input bit ep, input bit dr, input bit fl, input string tag);
    bit   enq_ok;
    bit   deq_ok;
    ent_t e;
    enq_valid_i = ev;
    enq_pc_i    = pc;
    enq_instr_i = ~pc ^ 32'h0000_0013;
    enq_fault_i = flt;
    enq_epoch_i = ep;
    deq_ready_i = dr;
    flush_i     = fl;
    e.pc    = pc;
    e.instr = ~pc ^ 32'h0000_0013;
    e.fault = flt;
    enq_ok = ev && (m_cnt < DEPTH) && !fl && (ep == m_epoch);
    deq_ok = dr && (m_cnt > 0) && !fl;
    @(posedge clk);
    if (fl) begin
      sb.delete();
      m_cnt   = 0;
      m_epoch = ~m_epoch;
    end else begin
      if (deq_ok) begin
        void'(sb.pop_front());
        m_cnt--;
      end
      if (enq_ok) begin
        sb.push_back(e);
        m_cnt++;
      end
    end
    @(negedge clk);
    enq_valid_i = 1'b0;
    deq_ready_i = 1'b0;
    flush_i     = 1'b0;
    check_outputs(tag);
  endtask

  initial begin
    logic [31:0] pc;
    rst_n       = 1'b0;
    flush_i     = 1'b0;
    enq_valid_i = 1'b0;
    enq_pc_i    = '0;
    enq_instr_i = '0;
    enq_fault_i = 1'b0;
    enq_epoch_i = 1'b0;
    deq_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Fill to full with decode stalled, then offer a ninth entry.
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b1, 32'h1000 + 32'(4 * i), 1'b0, m_epoch, 1'b0, 1'b0, "fill");
    check("full count", 64'(count_o), 64'(DEPTH));
    cycle(1'b1, 32'h1020, 1'b0, m_epoch, 1'b0, 1'b0, "ninth");

    // Drain in order.
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b0, 32'h0, 1'b0, m_epoch, 1'b1, 1'b0, "drain");

    // Occupancy 3 with 20 concurrent enqueue/dequeue cycles across the wrap.
    pc = 32'h3000;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, pc, 1'b0, m_epoch, 1'b0, 1'b0, "wrap pre");
      pc += 4;
    end
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, pc, 1'b0, m_epoch, 1'b1, 1'b0, "wrap");
      pc += 4;
    end
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 32'h0, 1'b0, m_epoch, 1'b1, 1'b0, "wrap drain");

    // Full plus dequeue: only the dequeue happens, enqueue lands next cycle.
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b1, 32'h4000 + 32'(4 * i), 1'b0, m_epoch, 1'b0, 1'b0, "refill");
    cycle(1'b1, 32'h4100, 1'b0, m_epoch, 1'b1, 1'b0, "full+deq");
    check("full+deq count", 64'(count_o), 64'(DEPTH - 1));
    cycle(1'b1, 32'h4100, 1'b0, m_epoch, 1'b0, 1'b0, "after full+deq");
    check("after full+deq count", 64'(count_o), 64'(DEPTH));
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b0, 32'h0, 1'b0, m_epoch, 1'b1, 1'b0, "drain2");

    // Fault flag travels with its own entry only.
    cycle(1'b1, 32'h5000, 1'b0, m_epoch, 1'b0, 1'b0, "fault a");
    cycle(1'b1, 32'h5004, 1'b1, m_epoch, 1'b0, 1'b0, "fault b");
    cycle(1'b1, 32'h5008, 1'b0, m_epoch, 1'b0, 1'b0, "fault c");
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 32'h0, 1'b0, m_epoch, 1'b1, 1'b0, "fault drain");

    // Flush with five entries queued under epoch 0.
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 32'h6000 + 32'(4 * i), 1'b0, m_epoch, 1'b0, 1'b0, "pre flush");
    check("pre flush epoch", 64'(epoch_o), 64'h0);
    cycle(1'b1, 32'h6100, 1'b0, m_epoch, 1'b1, 1'b1, "flush");
    check("post flush epoch", 64'(epoch_o), 64'h1);
    enq_valid_i = 1'b1;
    enq_epoch_i = 1'b0;
    check("stale ready", 64'(enq_ready_o), 64'h1);
    cycle(1'b1, 32'h6200, 1'b0, 1'b0, 1'b0, 1'b0, "stale");
    cycle(1'b1, 32'h2000, 1'b0, 1'b1, 1'b0, 1'b0, "new epoch");
    check("new epoch pc", 64'(deq_pc_o), 64'h2000);
    cycle(1'b0, 32'h0, 1'b0, m_epoch, 1'b0, 1'b1, "flush again");
    cycle(1'b0, 32'h0, 1'b0, m_epoch, 1'b0, 1'b1, "flush thrice");

    // Asynchronous reset with four entries queued, no clock edge.
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 32'h7000 + 32'(4 * i), 1'b0, m_epoch, 1'b0, 1'b0, "pre reset");
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    m_cnt   = 0;
    m_epoch = 1'b0;
    check_outputs("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 32'h0, 1'b0, m_epoch, 1'b1, 1'b0, "after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_inst_queue.md
# fetch_inst_queue

Instruction queue between the AXI4 instruction-fetch unit and the decode/control stage of the out-of-order RV32IMF core. Buffers fetched {PC, instruction, fault} entries in program order, presents the oldest entry to decode through a valid/ready handshake, and absorbs AXI read-latency jitter. On a redirect (branch/jump resolve, exception) it empties in one cycle. An epoch bit discards stale AXI responses that return after the flush.

## Interface
- DEPTH, 8: number of entries; power of two, ≥ 2.
- AF_MARGIN, 2: almost_full_o asserts when count_o ≥ DEPTH − AF_MARGIN.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush_i  in  1  redirect; empties the queue and toggles the epoch.
- enq_valid_i  in  1  fetch presents an entry.
- enq_ready_o  out  1  queue accepts an entry.
- enq_pc_i  in  32  PC of the fetched instruction.
- enq_instr_i  in  32  instruction word.
- enq_fault_i  in  1  AXI RRESP was SLVERR/DECERR.
- enq_epoch_i  in  1  epoch the fetch request was issued under.
- epoch_o  out  1  current epoch; fetch tags new requests with it.
- deq_valid_o  out  1  head entry valid.
- deq_ready_i  in  1  decode consumes the head.
- deq_pc_o  out  32  head PC.
- deq_instr_o  out  32  head instruction; decode slices opcode/funct3/funct7/rs2 from it.
- deq_fault_o  out  1  head fetch fault.
- count_o  out  $clog2(DEPTH)+1  occupancy.
- almost_full_o  out  1  throttle for outstanding AXI reads.

## Operation
- Storage: circular buffer of DEPTH entries of {pc[31:0], instr[31:0], fault}, with rd_ptr/wr_ptr of $clog2(DEPTH)+1 bits.
  - The extra MSB distinguishes full from empty.
  - empty = (rd_ptr == wr_ptr).
  - full = index bits equal and MSBs differ.
- enq_ready_o = !full. It is independent of deq_ready_i: there is no pass-through when full.
- Enqueue fires when enq_valid_i && enq_ready_o && !flush_i && (enq_epoch_i == epoch_o).
  - It writes at wr_ptr and increments wr_ptr. The pointer wraps naturally modulo 2·DEPTH.
- Stale response: enq_valid_i && enq_ready_o && (enq_epoch_i != epoch_o).
  - The handshake completes so the AXI channel drains.
  - The entry is discarded and no state changes.
- Dequeue fires when deq_valid_o && deq_ready_i. rd_ptr increments.
- deq_valid_o = !empty. deq_* outputs are driven from storage at rd_ptr.
  - When empty, deq_pc_o, deq_instr_o and deq_fault_o are 0. deq_instr_o is never X.
- Simultaneous enqueue and dequeue: both occur and count_o is unchanged.
  - If full, enqueue is blocked that cycle; the freed slot is visible next cycle.
- flush_i has priority over everything. On the next edge:
  - rd_ptr = wr_ptr = 0.
  - epoch toggles.
  - Enqueue and dequeue in the flush cycle are ignored for state.
- Faulting entries are queued like any other. Decode/ROB handles the exception.
- count_o = wr_ptr − rd_ptr, in pointer width.
- almost_full_o is combinational from count_o.

## Timing
- Reset (rst_n low, asynchronous):
  - rd_ptr = wr_ptr = 0, epoch = 0.
  - Outputs: deq_valid_o = 0, enq_ready_o = 1, count_o = 0, almost_full_o = 0, epoch_o = 0, deq_pc_o/deq_instr_o/deq_fault_o = 0.
  - Storage contents need not be reset.
- Reset deasserting mid-transaction: no handshakes are recorded while rst_n is low.
- Enqueue-to-dequeue latency: an entry enqueued at edge N is visible on deq_* after edge N, i.e. 1 cycle minimum. There is no combinational bypass from enq_* to deq_*.
- Throughput: 1 enqueue + 1 dequeue per cycle sustained.
- Handshake rules:
  - deq_* are stable while deq_valid_o && !deq_ready_i, unless flush_i is asserted.
  - The queue never revokes deq_valid_o except through flush.
- Flush: flush_i high at edge N gives deq_valid_o = 0 and enq_ready_o = 1 after N. epoch_o changes after N.
  - Back-to-back flushes each toggle the epoch.
- Combinational paths: enq_ready_o, deq_valid_o, count_o and almost_full_o depend only on registered state. No input-to-output combinational path exists.

## Test plan
- Reset then fill:
  - Enqueue 8 entries with PC 0x1000, 0x1004, … 0x101C, deq_ready_i = 0.
  - After the 8th: enq_ready_o = 0, count_o = 8, almost_full_o = 1 (asserted from count 6).
  - A 9th enq_valid_i is not accepted.
- Drain in order: deq_ready_i = 1 for 8 cycles → deq_pc_o sequence 0x1000…0x101C, then deq_valid_o = 0 and deq_instr_o = 0.
- Wrap-around with concurrent traffic:
  - Keep occupancy at 3 while doing 20 simultaneous enqueue/dequeue cycles.
  - count_o stays 3, order is preserved across the pointer wrap, and there are no drops or duplicates.
- Full plus dequeue: when full, assert enq_valid_i and deq_ready_i in the same cycle → only the dequeue occurs (count_o 8 → 7), and enqueue succeeds next cycle.
- Flush and stale epoch:
  - With 5 entries queued and epoch 0, assert flush_i. Next cycle: count_o = 0, epoch_o = 1.
  - A response tagged epoch 0 is handshaken but dropped (count_o stays 0).
  - A response tagged epoch 1 (PC 0x2000) appears on deq_pc_o next cycle.
- Async reset mid-stream: drop rst_n with 4 entries queued and no clock edge → outputs immediately match the reset values.
- Fault flag: enqueue with enq_fault_i = 1 → deq_fault_o = 1 for that entry only.
